// File: rtl/im_loader.sv
// im_loader: streams a length-prefixed big-endian byte image into instruction memory while holding the CPU.
//   clk, rst_n (async active-low)   start/abort: load control
//   byte_valid/byte_data/byte_ready: inbound byte stream handshake
//   im_we/im_waddr/im_wdata: one-cycle-per-word memory write port
//   cpu_hold, busy, done, err, word_count: status
module im_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE} state_t;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  state_t state, next;
  logic [15:0] len, n_in, wc_next;
  logic [31:0] word;
  logic [1:0]  bcnt;
  logic        acc, over, kill;
  assign byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign acc        = byte_valid && byte_ready;
  assign kill       = abort && (state != IDLE);
  assign n_in       = {len[15:8], byte_data};
  assign over       = {1'b0, n_in} > DEPTH_L;
  assign wc_next    = word_count + 16'd1;
  assign im_we      = state == WRITE;
  // address/data are gated to WRITE so the port never shows an index past DEPTH-1
  assign im_waddr   = im_we ? word_count[ADDR_W-1:0] : '0;
  assign im_wdata   = im_we ? word : '0;
  assign busy       = state != IDLE;
  assign cpu_hold   = state != IDLE;
  assign done       = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LEN_HI : IDLE;
      LEN_HI:  next = acc ? LEN_LO : LEN_HI;
      LEN_LO:  next = !acc ? LEN_LO : (n_in == 16'd0) ? DONE : over ? IDLE : DATA;
      DATA:    next = (acc && bcnt == 2'd3) ? WRITE : DATA;
      WRITE:   next = (wc_next == len) ? DONE : DATA;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (kill) next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len        <= '0;
      word       <= '0;
      bcnt       <= '0;
      err        <= 1'b0;
      word_count <= '0;
    end else if (state == IDLE && start) begin
      err        <= 1'b0;
      word_count <= '0;
      bcnt       <= '0;
    end else if (kill) begin
      bcnt <= '0;
    end else begin
      if (state == LEN_HI && acc) len[15:8] <= byte_data;
      if (state == LEN_LO && acc) begin
        len[7:0] <= byte_data;
        if (over) err <= 1'b1;
      end
      if (state == DATA && acc) begin
        word <= {word[23:0], byte_data};
        bcnt <= bcnt + 2'd1;
      end
      if (state == WRITE) word_count <= wc_next;
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed cycle table plus hand-written random-valid and mid-load reset sequences for im_loader.
module tb_im_loader;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, im_we, cpu_hold, busy, done, err;
  logic [9:0]  im_waddr;
  logic [31:0] im_wdata;
  logic [15:0] word_count;
  logic [63:0] obs;
  int tests = 0, fails = 0;

  im_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;
  assign obs = {byte_ready, im_we, im_waddr, im_wdata, cpu_hold, busy, done, err, word_count};

  typedef struct {
    logic        s, a, b;
    logic [7:0]  d;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic s, a, b, input logic [7:0] d, input logic r, we,
                             input logic [9:0] ad, input logic [31:0] wd,
                             input logic bz, dn, er, input logic [15:0] wc);
    vec_t x;
    x.s = s; x.a = a; x.b = b; x.d = d;
    x.exp = {r, we, ad, wd, bz, bz, dn, er, wc};
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic s, a, b, input logic [7:0] d);
    start = s; abort = a; byte_valid = b; byte_data = d;
  endtask

  initial begin
    logic [7:0]  img[14];
    logic [31:0] words[3];
    int idx, nwe, cyc;
    logic got_done;
    // two-word load
    tbl.push_back(v(1,0,0,8'h00, 0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h02, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h08, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h0C, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h05, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'hFF, 0,1,0,32'h08000C05, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h20, 1,0,0,0, 1,0,0,1));
    tbl.push_back(v(0,0,1,8'h11, 1,0,0,0, 1,0,0,1));
    tbl.push_back(v(0,0,1,8'h00, 1,0,0,0, 1,0,0,1));
    tbl.push_back(v(0,0,1,8'h01, 1,0,0,0, 1,0,0,1));
    tbl.push_back(v(0,0,0,8'h00, 0,1,1,32'h20110001, 1,0,0,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0,0, 1,1,0,2));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0,0, 0,0,0,2));
    // zero-length load
    tbl.push_back(v(1,0,0,8'h00, 0,0,0,0, 0,0,0,2));
    tbl.push_back(v(0,0,1,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0,0, 1,1,0,0));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0,0, 0,0,0,0));
    // N = 1025 overflows DEPTH
    tbl.push_back(v(1,0,0,8'h00, 0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,8'h04, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h01, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0,0, 0,0,1,0));
    tbl.push_back(v(0,1,0,8'h00, 0,0,0,0, 0,0,1,0));
    tbl.push_back(v(1,0,0,8'h00, 0,0,0,0, 0,0,1,0));
    tbl.push_back(v(1,0,0,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,1,1,8'h00, 1,0,0,0, 1,0,0,0));
    // start+abort in IDLE starts; abort on 3rd data byte
    tbl.push_back(v(1,1,0,8'h00, 0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h01, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'hAA, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'hBB, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,1,1,8'hCC, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'hDD, 0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0,0, 0,0,0,0));
    // N == DEPTH is accepted
    tbl.push_back(v(1,0,0,8'h00, 0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,8'h04, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,1,0,8'h00, 1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0,0, 0,0,0,0));

    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    #1 chk("reset", obs, 64'h0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].d);
      #1 chk($sformatf("row%0d", i), obs, tbl[i].exp);
    end

    // three-word load with random byte_valid gaps
    words[0] = 32'h01234567; words[1] = 32'h89ABCDEF; words[2] = 32'hCAFEF00D;
    img[0] = 8'h00; img[1] = 8'h03;
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 4; k++) img[2 + 4*w + k] = words[w][31 - 8*k -: 8];
    @(negedge clk);
    drive(1, 0, 0, 8'h00);
    idx = 0; nwe = 0; cyc = 0; got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      drive(0, 0, (idx < 14) && ($urandom_range(0, 1) == 1), img[idx < 14 ? idx : 13]);
      #1;
      if (im_we) begin
        chk($sformatf("rnd_we%0d", nwe), {31'h0, byte_ready, 22'h0, im_waddr, im_wdata},
            {32'h0, 22'h0, 10'(nwe), words[nwe < 3 ? nwe : 2]});
        nwe++;
      end
      if (done) got_done = 1'b1;
      if (byte_valid && byte_ready) idx++;
      cyc++;
    end
    chk("rnd_done", {63'h0, got_done}, 64'h1);
    chk("rnd_count", {32'(nwe), 16'h0, word_count}, {32'd3, 16'h0, 16'd3});

    // reset during DATA, then a normal one-word load
    @(negedge clk);
    drive(1, 0, 0, 8'h00);
    foreach (img[i]) if (i < 4) begin
      @(negedge clk);
      drive(0, 0, 1, i < 2 ? (i == 0 ? 8'h00 : 8'h01) : 8'h5A);
    end
    @(negedge clk);
    drive(0, 0, 0, 8'h00);
    #1 chk("pre_rst_busy", {63'h0, busy}, 64'h1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", obs, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 8'h00);
    img[0] = 8'h00; img[1] = 8'h01; img[2] = 8'hDE; img[3] = 8'hAD; img[4] = 8'hBE; img[5] = 8'hEF;
    idx = 0; nwe = 0; cyc = 0; got_done = 1'b0;
    while (!got_done && cyc < 50) begin
      @(negedge clk);
      drive(0, 0, idx < 6, img[idx < 6 ? idx : 5]);
      #1;
      if (im_we) begin
        chk("post_rst_we", {22'h0, im_waddr, im_wdata}, {32'h0, 32'hDEADBEEF});
        nwe++;
      end
      if (done) got_done = 1'b1;
      if (byte_valid && byte_ready) idx++;
      cyc++;
    end
    chk("post_rst_done", {32'(nwe), 31'h0, got_done}, {32'd1, 32'd1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
